// File: rtl/fetch_unit_pkg.sv
// Shared fetch types: queue entry layout reused by decode, plus width constants.
package fetch_unit_pkg;
  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// QDEPTH-entry prefetch FIFO with flush, push+pop when full, and combinational head.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush_i,
  input  logic      push_i,
  input  logic      pop_i,
  input  fq_entry_t din_i,
  output fq_entry_t head_o,
  output logic      valid_o,
  output logic      full_o
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  fq_entry_t       mem_q [QDEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            push_ok, pop_ok;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == CW'(QDEPTH));
  assign head_o  = valid_o ? mem_q[rd_q] : '0;

  // Guards keep count inside 0..QDEPTH regardless of caller behaviour.
  assign pop_ok  = pop_i & valid_o;
  assign push_ok = push_i & (!full_o | pop_ok);

  always_comb begin
    cnt_d = cnt_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (flush_i) begin
      cnt_d = '0;
      wr_d  = '0;
      rd_d  = '0;
    end else begin
      if (push_ok) wr_d = wr_q + PW'(1);
      if (pop_ok)  rd_d = rd_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i && !rst) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fills the prefetch queue, handles redirect/flush.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        misalign
);
  logic [31:0] pc_q, pc_d;
  logic        misalign_q, misalign_d;
  logic        deq, enq, q_full;
  fq_entry_t   head, din;

  assign deq = id_valid & id_ready;
  assign enq = !redirect & (!q_full | deq);
  assign din = '{inst: inst, pc: pc_q};

  fetch_queue #(.QDEPTH(QDEPTH)) u_q (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect),
    .push_i  (enq),
    .pop_i   (deq),
    .din_i   (din),
    .head_o  (head),
    .valid_o (id_valid),
    .full_o  (q_full)
  );

  assign inst_addr = pc_q;
  assign id_inst   = head.inst;
  assign id_pc     = head.pc;
  assign id_pc4    = id_valid ? head.pc + 32'(INST_BYTES) : '0;
  assign misalign  = misalign_q;

  // Redirect wins over fetch; the target is force-aligned to a word boundary.
  always_comb begin
    pc_d       = pc_q;
    misalign_d = redirect & (redirect_pc[1:0] != 2'b00);
    if (redirect)  pc_d = {redirect_pc[31:2], 2'b00};
    else if (enq)  pc_d = pc_q + 32'(INST_BYTES);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end
endmodule
